// File: rtl/switch_poll_ctrl.sv
// Avalon-MM master that time-shares the switch PIO between a periodic poll timer
// and a client read port. Polled samples are debounced and turned into rise/fall events.
// Latency: grant in IDLE -> read strobe +1 -> capture +2 -> ack/debounce update +3; events wait on evt_ready.
module switch_poll_ctrl #(
  parameter int DATA_W     = 8,
  parameter int POLL_DIV   = 50000,
  parameter int DEBOUNCE_N = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic [31:0]       avm_readdata,
  input  logic              rd_req,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] sw_stable,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [DATA_W-1:0] evt_rise,
  output logic [DATA_W-1:0] evt_fall
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

  localparam logic [CNT_W-1:0] TICK_CNT = CNT_W'(POLL_DIV - 1);
  localparam logic [3:0]       DBN      = 4'(DEBOUNCE_N);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   poll_cnt;
  logic               poll_pending;
  logic               last_poll;     // source of the current / most recent grant (1 = poll)
  logic [DATA_W-1:0]  cand;
  logic [3:0]         run_cnt;

  logic               tick;
  logic               grant;
  logic               grant_poll;
  logic [DATA_W-1:0]  samp;
  logic               poll_capture;
  logic [3:0]         run_upd;
  logic               stable_chg;
  logic [DATA_W-1:0]  rise_new;
  logic [DATA_W-1:0]  fall_new;

  generate
    if (DATA_W < 32) begin : g_unused_hi
      logic unused_rdata;
      assign unused_rdata = ^avm_readdata[31:DATA_W];
    end
  endgenerate

  assign samp = avm_readdata[DATA_W-1:0];
  assign tick = (poll_cnt == TICK_CNT);

  // Round-robin: with both requesting, the source not granted last wins.
  assign grant      = (state == IDLE) && (poll_pending || rd_req);
  assign grant_poll = poll_pending && (!rd_req || !last_poll);

  // Debounce update is computed from the readdata returned during CAPTURE so the
  // new stable value and any event are visible in the DONE cycle.
  assign poll_capture = (state == CAPTURE) && last_poll;
  assign run_upd      = (samp == cand) ? ((run_cnt == DBN) ? run_cnt : run_cnt + 4'd1) : 4'd1;
  assign stable_chg   = poll_capture && (run_upd == DBN) && (samp != sw_stable);
  assign rise_new     = samp & ~sw_stable;
  assign fall_new     = ~samp & sw_stable;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic: fixed four-cycle access once granted
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (poll_pending || rd_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: read strobe only in ISSUE, client ack only in a client DONE
  always_comb begin
    avm_address = 2'd0;
    avm_read    = 1'b0;
    rd_ack      = 1'b0;
    case (state)
      ISSUE:   avm_read = 1'b1;
      DONE:    rd_ack   = !last_poll;
      default: ;
    endcase
  end

  // Poll timer; a tick while a poll is already pending is dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt     <= '0;
      poll_pending <= 1'b0;
    end else if (!enable) begin
      poll_cnt     <= '0;
      poll_pending <= 1'b0;
    end else begin
      poll_cnt <= tick ? '0 : poll_cnt + 1'b1;
      if (tick && !poll_pending)    poll_pending <= 1'b1;
      else if (grant && grant_poll) poll_pending <= 1'b0;
    end
  end

  // Remember which source owns the access in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   last_poll <= 1'b0;
    else if (grant) last_poll <= grant_poll;
  end

  // Client sample; held until the next client access completes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           rd_data <= '0;
    else if (state == CAPTURE && !last_poll) rd_data <= samp;
  end

  // Debounce: candidate value, run length and the stable state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand      <= '0;
      run_cnt   <= '0;
      sw_stable <= '0;
    end else if (poll_capture) begin
      cand    <= samp;
      run_cnt <= run_upd;
      if (stable_chg) sw_stable <= samp;
    end
  end

  // Event registers: load, coalesce while stalled, replace on simultaneous handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid <= 1'b0;
      evt_rise  <= '0;
      evt_fall  <= '0;
    end else if (stable_chg) begin
      evt_valid <= 1'b1;
      if (!evt_valid || evt_ready) begin
        evt_rise <= rise_new;
        evt_fall <= fall_new;
      end else begin
        evt_rise <= evt_rise | rise_new;
        evt_fall <= evt_fall | fall_new;
      end
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
      evt_rise  <= '0;
      evt_fall  <= '0;
    end
  end

endmodule
